// File: rtl/sfr_arb_pkg.sv
// Shared types and helpers for the SFR bus arbiter.
// Optional feature macro used by the arbiter: SFR_ARB_LOCK_EN.
package sfr_arb_pkg;

    // Upper bound on requesters; id and pointer fields are sized for it.
    localparam int MAX_REQ = 16;
    localparam int ID_W    = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Next requester id after 'id', wrapping to 0 past 'last'.
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id,
                                                 input logic [ID_W-1:0] last);
        logic [ID_W-1:0] nxt;
        if (id == last) begin
            nxt = '0;
        end else begin
            nxt = id + {{(ID_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sfr_rr_arbiter.sv
// Combinational rotate-priority pick: first eligible requester at or after ptr.
module sfr_rr_arbiter
    import sfr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    win_id
);

    logic found_s;
    logic hit_s;

    // Walk priority offsets 0..NUM_REQ-1 from ptr; the first eligible hit wins.
    always_comb begin
        gnt     = '0;
        win_id  = '0;
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                hit_s   = !found_s && req[j] && elig[j]
                          && (((int'(ptr) + k) % NUM_REQ) == j);
                gnt[j]  = gnt[j] | hit_s;
                win_id  = hit_s ? ID_W'(j) : win_id;
                found_s = found_s | hit_s;
            end
        end
    end

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Round-robin sequencer sharing one SFR bus: IDLE (arbitrate) -> STROBE -> RESP.
// Optional macro SFR_ARB_LOCK_EN adds req_lock and a per-requester bus lock.
module sfr_bus_arbiter
    import sfr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
`ifdef SFR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]              req_lock,
`endif
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0]           address,
    output logic [DATA_WIDTH-1:0]           write_data,
    output logic                            we,
    output logic                            re,
    input  logic [DATA_WIDTH-1:0]           read_data,
    output logic                            busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0]   address_q, address_d;
    logic [DATA_WIDTH-1:0]   write_data_q, write_data_d;
    logic                    we_q, we_d;
    logic                    re_q, re_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    busy_q, busy_d;
    logic                    lock_q, lock_d;
    logic [ID_W-1:0]         lock_id_q, lock_id_d;
    logic                    lock_req_q, lock_req_d;

    logic [NUM_REQ-1:0]      gnt_s;
    logic [NUM_REQ-1:0]      elig_s;
    logic [ID_W-1:0]         win_s;
    logic                    accept_s;
    logic                    sel_we_s;
    logic                    sel_lock_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    sfr_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .elig   (elig_s),
        .gnt    (gnt_s),
        .win_id (win_s)
    );

    // Eligibility: everybody, or only the lock holder while a lock is held.
    always_comb begin
        if (lock_q) begin
            elig_s = NUM_REQ'(1) << lock_id_q;
        end else begin
            elig_s = '1;
        end
    end

    // Acceptance handshake is only offered while idle and out of reset.
    always_comb begin
        if ((state_q == IDLE) && !reset) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
    end

    assign accept_s = |(req_valid & req_ready);

    // One-hot mux of the winning requester's command fields.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sel_we_s    = sel_we_s | (gnt_s[j] & req_we[j]);
`ifdef SFR_ARB_LOCK_EN
            sel_lock_s  = sel_lock_s | (gnt_s[j] & req_lock[j]);
`endif
            sel_addr_s  = sel_addr_s
                          | (req_addr[j*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{gnt_s[j]}});
            sel_wdata_s = sel_wdata_s
                          | (req_wdata[j*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt_s[j]}});
        end
    end

    // Next-state and output computation for the transaction sequencer.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        is_wr_d      = is_wr_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        we_d         = 1'b0;
        re_d         = 1'b0;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        lock_req_d   = lock_req_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d      = STROBE;
                    id_d         = win_s;
                    is_wr_d      = sel_we_s;
                    address_d    = sel_addr_s;
                    write_data_d = sel_wdata_s;
                    we_d         = sel_we_s;
                    re_d         = !sel_we_s;
                    lock_req_d   = sel_lock_s;
                    // The pointer is frozen while a lock is held.
                    ptr_d        = lock_q ? ptr_q : wrap_inc(win_s, LAST_ID);
                end else begin
                    state_d = IDLE;
                end
            end
            STROBE: begin
                state_d     = RESP;
                rsp_valid_d = NUM_REQ'(1) << id_q;
                rsp_rdata_d = is_wr_q ? {DATA_WIDTH{1'b0}} : read_data;
            end
            RESP: begin
                state_d = IDLE;
                if (lock_req_q) begin
                    lock_d    = 1'b1;
                    lock_id_d = id_q;
                end else if (lock_q && (lock_id_q == id_q)) begin
                    lock_d    = 1'b0;
                end else begin
                    lock_d    = lock_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer, lock and bus registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            is_wr_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            we_q         <= 1'b0;
            re_q         <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            lock_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            is_wr_q      <= is_wr_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            we_q         <= we_d;
            re_q         <= re_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            busy_q       <= busy_d;
`ifdef SFR_ARB_LOCK_EN
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            lock_req_q   <= lock_req_d;
`else
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            lock_req_q   <= 1'b0;
`endif
        end
    end

    assign address    = address_q;
    assign write_data = write_data_q;
    assign we         = we_q;
    assign re         = re_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sfr_bus_arbiter.sv
// Scoreboard bench for sfr_bus_arbiter: a transaction-level model predicts
// grants, pushes expected bus/response items to a queue, and pops them as the
// DUT produces strobes and responses. Honours SFR_ARB_LOCK_EN when defined.
module tb_sfr_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N-1:0]         req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0]      req_addr;
    logic [N*DW-1:0]      req_wdata;
    logic [DW-1:0]        rsp_rdata, write_data, read_data;
    logic [AW-1:0]        address;
    logic                 we, re, busy;
`ifdef SFR_ARB_LOCK_EN
    logic [N-1:0]         req_lock;
`endif

    logic [DW-1:0] rd_mem [0:255];
    assign read_data = rd_mem[address];

    sfr_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef SFR_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .address(address), .write_data(write_data), .we(we), .re(re),
        .read_data(read_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        id;
        bit        wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        bit        lock;
    } txn_t;

    txn_t sb[$];
    int   grants[$];
    int   gcyc[$];

    int n_chk  = 0;
    int n_pass = 0;

    // requester-side stimulus state
    bit         p_valid [N];
    bit         p_we    [N];
    bit         p_cont  [N];
    bit         p_lock  [N];
    logic [7:0] p_addr  [N];
    logic [7:0] p_wdata [N];

    // model state
    bit         started = 1'b0;
    int         cyc     = 0;
    int         m_state = 0;
    int         m_ptr   = 0;
    logic [7:0] m_addr  = 8'h00;
    logic [7:0] m_wdata = 8'h00;
    logic [7:0] m_rdata = 8'h00;
    bit         m_lock  = 1'b0;
    int         m_lock_id = 0;
    bit         m_acc   = 1'b0;
    int         m_acc_id = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model step and per-cycle output checks, away from the rising edge.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int   win;
        int   gi;
        txn_t t;
        if (started) begin
            cyc++;
            exp_rdy = '0;
            win = -1;
            if (m_state == 0 && !reset) begin
                for (int k = 0; k < N; k++) begin
                    int id;
                    id = (m_ptr + k) % N;
                    if (win < 0 && req_valid[id] && (!m_lock || id == m_lock_id)) win = id;
                end
            end
            if (win >= 0) exp_rdy[win] = 1'b1;
            check_eq("req_ready", req_ready, exp_rdy);
            if (req_ready != '0) begin
                gi = 0;
                for (int k = 0; k < N; k++) if (req_ready[k]) gi = k;
                grants.push_back(gi);
                gcyc.push_back(cyc);
            end
            check_eq("busy", busy, (m_state != 0));
            if (m_state == 0) begin
                check_eq("idle_we", we, 0);
                check_eq("idle_re", re, 0);
                check_eq("idle_rsp", rsp_valid, 0);
                check_eq("idle_rdata", rsp_rdata, m_rdata);
                check_eq("idle_addr", address, m_addr);
                check_eq("idle_wdata", write_data, m_wdata);
            end else if (m_state == 1) begin
                check_eq("sb_nonempty", sb.size(), 1);
                if (sb.size() > 0) begin
                    t = sb[0];
                    check_eq("strobe_we", we, t.wr);
                    check_eq("strobe_re", re, !t.wr);
                    check_eq("strobe_addr", address, t.addr);
                    if (t.wr) check_eq("strobe_wdata", write_data, t.wdata);
                end
                check_eq("strobe_rsp", rsp_valid, 0);
            end else begin
                check_eq("sb_nonempty", sb.size(), 1);
                if (sb.size() > 0) begin
                    t = sb.pop_front();
                    check_eq("rsp_valid", rsp_valid, (1 << t.id));
                    check_eq("rsp_rdata", rsp_rdata, t.rdata);
                    if (m_lock_upd(t)) m_lock = 1'b1;
                end
                check_eq("resp_we", we, 0);
                check_eq("resp_re", re, 0);
            end
            // advance the model to the state after the coming edge
            m_acc = 1'b0;
            if (reset) begin
                m_state = 0; m_ptr = 0; m_addr = 8'h00; m_wdata = 8'h00;
                m_rdata = 8'h00; m_lock = 1'b0; m_lock_id = 0;
                sb.delete();
            end else if (m_state == 0) begin
                if (win >= 0) begin
                    t.id = win;
                    t.wr = req_we[win];
                    t.addr = req_addr[win*AW +: AW];
                    t.wdata = req_wdata[win*DW +: DW];
                    t.rdata = t.wr ? 8'h00 : rd_mem[t.addr];
`ifdef SFR_ARB_LOCK_EN
                    t.lock = req_lock[win];
`else
                    t.lock = 1'b0;
`endif
                    sb.push_back(t);
                    m_acc = 1'b1; m_acc_id = win;
                    if (!m_lock) m_ptr = (win + 1) % N;
                    m_addr = t.addr; m_wdata = t.wdata;
                    m_state = 1;
                end
            end else if (m_state == 1) begin
                if (sb.size() > 0) m_rdata = sb[0].rdata;
                m_state = 2;
            end else begin
                m_state = 0;
            end
        end
    end

    // Lock bookkeeping on transaction completion; returns 1 when a lock is set.
    function automatic bit m_lock_upd(input txn_t t);
        if (t.lock) begin
            m_lock_id = t.id;
            return 1'b1;
        end else begin
            if (m_lock && t.id == m_lock_id) m_lock = 1'b0;
            return 1'b0;
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = p_valid[i];
            req_we[i]    = p_we[i];
            req_addr[i*AW +: AW]  = p_addr[i];
            req_wdata[i*DW +: DW] = p_wdata[i];
`ifdef SFR_ARB_LOCK_EN
            req_lock[i]  = p_lock[i];
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (m_acc) begin
            if (p_cont[m_acc_id]) begin
                p_addr[m_acc_id]  = p_addr[m_acc_id] + 8'd1;
                p_wdata[m_acc_id] = p_wdata[m_acc_id] + 8'd3;
            end else begin
                p_valid[m_acc_id] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic set_req(input int id, input bit wr, input logic [7:0] a, input logic [7:0] d);
        p_valid[id] = 1'b1; p_we[id] = wr; p_addr[id] = a; p_wdata[id] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_cont[i] = 1'b0; p_lock[i] = 1'b0;
        end
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || m_state != 0 || req_valid != '0) && n < 80) begin
            step();
            n++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_grant(input string tag, input int idx, input int exp);
        check_eq(tag, (idx < grants.size()) ? grants[idx] : 99, exp);
    endtask

    initial begin
        int gb;
        int n;
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i * 7 + 3);
        rd_mem[8'h10] = 8'h5A;
        for (int i = 0; i < N; i++) begin
            p_valid[i] = 1'b0; p_we[i] = 1'b0; p_cont[i] = 1'b0; p_lock[i] = 1'b0;
            p_addr[i] = 8'h00; p_wdata[i] = 8'h00;
        end
        reset = 1'b1;
        drive();
        @(posedge clk);
        #1;
        started = 1'b1;
        step();
        check_eq("rst_addr", address, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdata", rsp_rdata, 0);
        reset = 1'b0;

        // single write from requester 2
        gb = grants.size();
        set_req(2, 1'b1, 8'h3C, 8'hA5);
        drive();
        drain();
        check_grant("wr_grant", gb, 2);

        // single read from requester 0
        gb = grants.size();
        set_req(0, 1'b0, 8'h10, 8'h00);
        drive();
        drain();
        check_grant("rd_grant", gb, 0);
        check_eq("rd_hold_rdata", rsp_rdata, 8'h5A);

        // fairness: all requesting continuously from reset
        do_reset();
        gb = grants.size();
        for (int i = 0; i < N; i++) begin
            set_req(i, i[0], 8'(8'h40 + i * 16), 8'(i));
            p_cont[i] = 1'b1;
        end
        drive();
        for (int s = 0; s < 26; s++) step();
        clear_all();
        drain();
        for (int i = 0; i < 8; i++) check_grant("fair_order", gb + i, i % N);
        for (int i = 0; i < 7; i++)
            check_eq("fair_gap", (gb + i + 1 < gcyc.size()) ? gcyc[gb+i+1] - gcyc[gb+i] : 0, 3);

        // pointer wrap: grant 2 first (ptr -> 3), then 1 and 3 together
        set_req(2, 1'b1, 8'h01, 8'h11);
        drive();
        drain();
        gb = grants.size();
        set_req(1, 1'b0, 8'h21, 8'h00);
        set_req(3, 1'b1, 8'h23, 8'h33);
        drive();
        drain();
        check_grant("wrap_first", gb, 3);
        check_grant("wrap_second", gb + 1, 1);

        // reset during a read strobe
        set_req(1, 1'b0, 8'h22, 8'h00);
        drive();
        n = 0;
        while (m_state != 1 && n < 20) begin step(); n++; end
        check_eq("mid_reach_strobe", m_state, 1);
        reset = 1'b1;
        step();
        check_eq("mid_re", re, 0);
        check_eq("mid_we", we, 0);
        check_eq("mid_rsp", rsp_valid, 0);
        check_eq("mid_busy", busy, 0);
        check_eq("mid_addr", address, 0);
        reset = 1'b0;
        gb = grants.size();
        set_req(0, 1'b1, 8'h30, 8'h44);
        set_req(2, 1'b0, 8'h32, 8'h00);
        drive();
        drain();
        check_grant("mid_next0", gb, 0);
        check_grant("mid_next2", gb + 1, 2);

        // random traffic with requests dropped before acceptance
        for (int s = 0; s < 60; s++) begin
            for (int i = 0; i < N; i++) begin
                if (!p_valid[i] && ($urandom % 3 == 0))
                    set_req(i, 1'($urandom), 8'($urandom), 8'($urandom));
                else if (p_valid[i] && ($urandom % 8 == 0))
                    p_valid[i] = 1'b0;
            end
            drive();
            step();
        end
        clear_all();
        drain();

`ifdef SFR_ARB_LOCK_EN
        // lock: requester 1 holds the bus while requester 0 keeps asking
        do_reset();
        set_req(0, 1'b1, 8'h50, 8'h01);
        drive();
        drain();
        gb = grants.size();
        set_req(0, 1'b1, 8'h51, 8'h02);
        p_cont[0] = 1'b1;
        set_req(1, 1'b0, 8'h60, 8'h00);
        p_cont[1] = 1'b1;
        p_lock[1] = 1'b1;
        drive();
        n = 0;
        for (int s = 0; s < 20; s++) begin
            step();
            if (m_acc && m_acc_id == 1) begin
                n++;
                if (n == 2) p_lock[1] = 1'b0;
                if (n == 3) begin p_valid[1] = 1'b0; p_cont[1] = 1'b0; end
                drive();
            end
        end
        clear_all();
        drain();
        check_grant("lock_g0", gb, 1);
        check_grant("lock_g1", gb + 1, 1);
        check_grant("lock_g2", gb + 2, 1);
        check_grant("lock_g3", gb + 3, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
